// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
//
// Purpose:
//   Direct-mapped branch target buffer with 2-bit saturating counters.
//   - Fetch side: a one-cycle registered lookup returns a taken/not-taken
//     prediction and a predicted next PC.
//   - Execute side: a resolving branch or jump trains the BTB. A registered
//     one-cycle mispredict pulse and the correct redirect PC are produced.
//
// Optional feature (macro BPU_STATS_EN):
//   - Defined: saturating 32-bit counters for lookups and mispredicts.
//   - Undefined: the counter logic is absent and both ports read 0.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   fetch_valid, fetch_pc            lookup request
//   pred_valid, pred_taken,
//   pred_target                      registered lookup result
//   ex_valid, ex_is_branch,
//   ex_is_jump, ex_taken,
//   ex_pred_taken                    resolving instruction, class, outcome,
//                                    and the prediction it carried
//   ex_pc, updated_pc, instruction,
//   branch_offset, ex_pred_target    branch PC, PC+4, instruction word,
//                                    sign-extended offset, carried target
//   branch_pc, jump_pc               combinational branch and jump targets
//   mispredict, redirect_pc          registered redirect pulse and correct PC
//   stat_lookups, stat_mispredicts   statistics counters
// ----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int DATA_W    = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] updated_pc,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] branch_offset,
    input  logic [DATA_W-1:0] ex_pred_target,
    output logic [DATA_W-1:0] branch_pc,
    output logic [DATA_W-1:0] jump_pc,
    output logic              mispredict,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = DATA_W - 2 - IDX_W;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // BTB storage: valid and counter are control state; tag and target
    // are plain data.
    logic [BTB_DEPTH-1:0] btb_vld;
    logic [1:0]           btb_ctr [BTB_DEPTH];
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [DATA_W-1:0]    btb_tgt [BTB_DEPTH];

    // Target computation
    logic signed [DATA_W-1:0] off_s;
    logic signed [DATA_W-1:0] upc_s;

    assign off_s     = branch_offset;
    assign upc_s     = updated_pc;
    assign branch_pc = upc_s + (off_s <<< 2);
    assign jump_pc   = {updated_pc[DATA_W-1:28], instruction[25:0], 2'b00};

    // Lookup: reads current array contents, so a same-cycle update of the
    // same index is seen only by the following lookup.
    logic [IDX_W-1:0]  idx_l;
    logic [TAG_W-1:0]  tag_l;
    logic              hit_l;
    logic              take_l;
    logic [DATA_W-1:0] tgt_l;

    assign idx_l  = fetch_pc[IDX_W+1:2];
    assign tag_l  = fetch_pc[DATA_W-1:IDX_W+2];
    assign hit_l  = btb_vld[idx_l] && (btb_tag[idx_l] == tag_l);
    assign take_l = hit_l && btb_ctr[idx_l][1];
    assign tgt_l  = take_l ? btb_tgt[idx_l] : fetch_pc + DATA_W'(4);

    // Resolution
    logic              act_taken;
    logic [DATA_W-1:0] act_target;
    logic              upd;
    logic [IDX_W-1:0]  idx_u;
    logic [TAG_W-1:0]  tag_u;
    logic              hit_u;
    logic              mis_next;

    assign act_taken  = ex_is_jump | (ex_is_branch & ex_taken);
    assign act_target = ex_is_jump ? jump_pc : branch_pc;
    assign upd        = ex_valid & (ex_is_branch | ex_is_jump);
    assign idx_u      = ex_pc[IDX_W+1:2];
    assign tag_u      = ex_pc[DATA_W-1:IDX_W+2];
    assign hit_u      = btb_vld[idx_u] && (btb_tag[idx_u] == tag_u);
    assign mis_next   = ex_valid &&
                        ((act_taken != ex_pred_taken) ||
                         (act_taken && (ex_pred_target != act_target)));

    // BTB control update
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_vld <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_ctr[i] <= 2'b01;
            end
        end else if (upd) begin
            if (hit_u) begin
                if (ex_is_jump) begin
                    btb_ctr[idx_u] <= 2'b11;
                end else if (act_taken) begin
                    btb_ctr[idx_u] <= ctr_inc(btb_ctr[idx_u]);
                end else begin
                    btb_ctr[idx_u] <= ctr_dec(btb_ctr[idx_u]);
                end
            end else if (act_taken) begin
                btb_vld[idx_u] <= 1'b1;
                btb_ctr[idx_u] <= ex_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // BTB data update: any taken update (hit or allocate) writes tag and
    // target; on a hit the tag rewrite is a no-op.
    always_ff @(posedge clk) begin
        if (!rst && upd && act_taken) begin
            btb_tag[idx_u] <= tag_u;
            btb_tgt[idx_u] <= act_target;
        end
    end

    // ---- stage p1: registered lookup and redirect results ----
    logic              vld_p1;
    logic              taken_p1;
    logic [DATA_W-1:0] target_p1;
    logic              mis_p1;
    logic [DATA_W-1:0] redir_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            taken_p1  <= 1'b0;
            target_p1 <= '0;
            mis_p1    <= 1'b0;
            redir_p1  <= '0;
        end else begin
            vld_p1   <= fetch_valid;
            taken_p1 <= fetch_valid & take_l;
            if (fetch_valid) begin
                target_p1 <= tgt_l;
            end
            mis_p1 <= mis_next;
            if (ex_valid) begin
                redir_p1 <= act_taken ? act_target : updated_pc;
            end
        end
    end

    assign pred_valid  = vld_p1;
    assign pred_taken  = taken_p1;
    assign pred_target = target_p1;
    assign mispredict  = mis_p1;
    assign redirect_pc = redir_p1;

`ifdef BPU_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [31:0] lookups_p1;
    logic [31:0] mispredicts_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_p1     <= '0;
            mispredicts_p1 <= '0;
        end else begin
            if (fetch_valid) begin
                lookups_p1 <= sat_inc32(lookups_p1);
            end
            if (mis_next) begin
                mispredicts_p1 <= sat_inc32(mispredicts_p1);
            end
        end
    end

    assign stat_lookups     = lookups_p1;
    assign stat_mispredicts = mispredicts_p1;
`else
    assign stat_lookups     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

    logic unused_bits;
    assign unused_bits = ^{ex_pc[1:0], instruction[DATA_W-1:26]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, updated_pc, instruction, branch_offset, ex_pred_target;
    logic [31:0] branch_pc, jump_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_lookups, stat_mispredicts;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.DATA_W(32), .BTB_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .updated_pc(updated_pc), .instruction(instruction),
        .branch_offset(branch_offset), .ex_pred_target(ex_pred_target),
        .branch_pc(branch_pc), .jump_pc(jump_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ex_set(input logic br, input logic jp, input logic tk, input logic ptk,
                          input logic [31:0] pc, input logic [31:0] upc,
                          input logic [31:0] ins, input logic [31:0] off,
                          input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = br;
        ex_is_jump     = jp;
        ex_taken       = tk;
        ex_pred_taken  = ptk;
        ex_pc          = pc;
        updated_pc     = upc;
        instruction    = ins;
        branch_offset  = off;
        ex_pred_target = ptgt;
    endtask

    task automatic ex_clr();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; updated_pc = '0; instruction = '0;
        branch_offset = '0; ex_pred_target = '0;
    endtask

    // One update cycle of the branch at 0x40 (PC+4 = 0x44, offset 3 -> 0x50)
    task automatic br40(input string tag, input logic tk, input logic ptk,
                        input logic [31:0] ptgt, input logic exp_mis,
                        input logic [31:0] exp_redir);
        ex_set(1'b1, 1'b0, tk, ptk, 32'h40, 32'h44, 32'h0, 32'd3, ptgt);
        tick();
        ex_clr();
        chk({tag, "_mis"}, {31'd0, mispredict}, {31'd0, exp_mis});
        chk({tag, "_redir"}, redirect_pc, exp_redir);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic exp_tk, input logic [31:0] exp_tgt);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
        chk({tag, "_pv"}, {31'd0, pred_valid}, 32'd1);
        chk({tag, "_pt"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({tag, "_tgt"}, pred_target, exp_tgt);
    endtask

    initial begin
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc = '0;
        ex_clr();
        // Taken branch at 0x80 present during reset must be discarded.
        ex_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h84, 32'h0, 32'd3, 32'h0);
        @(negedge clk);
        tick();
        chk("rst_pv", {31'd0, pred_valid}, 32'd0);
        chk("rst_pt", {31'd0, pred_taken}, 32'd0);
        chk("rst_tgt", pred_target, 32'd0);
        chk("rst_mis", {31'd0, mispredict}, 32'd0);
        chk("rst_redir", redirect_pc, 32'd0);
        chk("rst_slk", stat_lookups, 32'd0);
        chk("rst_smp", stat_mispredicts, 32'd0);
        ex_clr();
        rst = 1'b0;

        // Cold lookup, then idle cycle holds target
        fetch("cold40", 32'h40, 1'b0, 32'h44);
        tick();
        chk("idle_pv", {31'd0, pred_valid}, 32'd0);
        chk("idle_pt", {31'd0, pred_taken}, 32'd0);
        chk("idle_tgt", pred_target, 32'h44);

        // Same-cycle lookup and taken update of 0x40: lookup sees old contents
        fetch_valid = 1'b1;
        fetch_pc    = 32'h40;
        ex_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h44, 32'h0, 32'd3, 32'h0);
        #1;
        chk("branch_pc", branch_pc, 32'h50);
        tick();
        fetch_valid = 1'b0;
        ex_clr();
        chk("rbw_pt", {31'd0, pred_taken}, 32'd0);
        chk("rbw_tgt", pred_target, 32'h44);
        chk("alloc_mis", {31'd0, mispredict}, 32'd1);
        chk("alloc_redir", redirect_pc, 32'h50);
        fetch("hit40", 32'h40, 1'b1, 32'h50);
        chk("quiet_mis", {31'd0, mispredict}, 32'd0);
        chk("hold_redir", redirect_pc, 32'h50);

        // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        br40("nt1", 1'b0, 1'b1, 32'h50, 1'b1, 32'h44);
        fetch("f_c01", 32'h40, 1'b0, 32'h44);
        br40("nt2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
        fetch("f_c00", 32'h40, 1'b0, 32'h44);
        br40("nt3", 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
        br40("tk1", 1'b1, 1'b0, 32'h0, 1'b1, 32'h50);
        fetch("f_lo_sat", 32'h40, 1'b0, 32'h44);
        br40("tk2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h50);
        fetch("f_c10", 32'h40, 1'b1, 32'h50);
        br40("tk3", 1'b1, 1'b1, 32'h50, 1'b0, 32'h50);
        br40("tk4", 1'b1, 1'b1, 32'h50, 1'b0, 32'h50);
        br40("nt4", 1'b0, 1'b1, 32'h50, 1'b1, 32'h44);
        fetch("f_hi_sat", 32'h40, 1'b1, 32'h50);

        // Correct direction, wrong target
        br40("badtgt", 1'b1, 1'b1, 32'h60, 1'b1, 32'h50);

        // Non-control instruction: BTB untouched, mispredict with act_taken=0
        ex_set(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h44, 32'h0, 32'd3, 32'h50);
        tick();
        ex_clr();
        chk("nc_mis", {31'd0, mispredict}, 32'd1);
        chk("nc_redir", redirect_pc, 32'h44);
        fetch("f_nc", 32'h40, 1'b1, 32'h50);

        // Tag mismatch on shared index, and reset-cycle update was discarded
        fetch("tagmiss", 32'h440, 1'b0, 32'h444);
        fetch("rst_upd", 32'h80, 1'b0, 32'h84);

        // Jump allocates with counter 11
        ex_set(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h1000_0008,
               32'h0800_0100, 32'h0, 32'h0);
        #1;
        chk("jump_pc", jump_pc, 32'h1000_0400);
        tick();
        ex_clr();
        chk("jmp_mis", {31'd0, mispredict}, 32'd1);
        chk("jmp_redir", redirect_pc, 32'h1000_0400);
        fetch("f_jmp", 32'h1000_0004, 1'b1, 32'h1000_0400);
        ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 32'h1000_0008, 32'h0, 32'h0, 32'h1000_0400);
        tick();
        ex_clr();
        chk("jnt1_redir", redirect_pc, 32'h1000_0008);
        fetch("f_j10", 32'h1000_0004, 1'b1, 32'h1000_0400);
        ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 32'h1000_0008, 32'h0, 32'h0, 32'h1000_0400);
        tick();
        ex_clr();
        fetch("f_j01", 32'h1000_0004, 1'b0, 32'h1000_0008);

        // Statistics: 5 lookups, 2 mispredicts after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("srst_slk", stat_lookups, 32'd0);
        chk("srst_smp", stat_mispredicts, 32'd0);
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 32'h100 + 32'(i * 4);
            if (i < 2) ex_set(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h104, 32'h0, 32'h0, 32'h0);
            else ex_clr();
            tick();
        end
        fetch_valid = 1'b0;
        ex_clr();
        tick();
`ifdef BPU_STATS_EN
        chk("st_lk", stat_lookups, 32'd5);
        chk("st_mp", stat_mispredicts, 32'd2);
`else
        chk("st_lk", stat_lookups, 32'd0);
        chk("st_mp", stat_mispredicts, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_rst_lk", stat_lookups, 32'd0);
        chk("st_rst_mp", stat_mispredicts, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter: DATA_W, 32, datapath/PC width; SHALL be >= 32.
REQ-002 Parameter: BTB_DEPTH, 16, number of BTB entries; SHALL be a power of two, >= 2; IDX_W = log2(BTB_DEPTH).
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: fetch_valid  in  1  lookup request.
REQ-006 Port: fetch_pc  in  DATA_W  PC being fetched.
REQ-007 Port: pred_valid / pred_taken  out  1 / 1  registered lookup result.
REQ-008 Port: pred_target  out  DATA_W  registered predicted target.
REQ-009 Port: ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken  in  1 each  resolving control instruction, its class, its actual branch outcome, and the prediction it carried.
REQ-010 Port: ex_pc, updated_pc, instruction, branch_offset, ex_pred_target  in  DATA_W each  branch PC, PC+4, instruction word, sign-extended offset, predicted target carried.
REQ-011 Port: branch_pc, jump_pc  out  DATA_W each  combinational targets.
REQ-012 Port: mispredict  out  1  registered one-cycle redirect pulse.
REQ-013 Port: redirect_pc  out  DATA_W  registered correct next PC.
REQ-014 Port: stat_lookups, stat_mispredicts  out  32 each  statistics counters (see REQ-033).

Function
REQ-015 branch_pc SHALL equal updated_pc + (branch_offset << 2), signed, truncated to DATA_W.
REQ-016 jump_pc SHALL equal {updated_pc[DATA_W-1:28], instruction[25:0], 2'b00}.
REQ-017 BTB entry SHALL hold: valid (1), tag (DATA_W-2-IDX_W), target (DATA_W), 2-bit saturating counter.
REQ-018 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[DATA_W-1:IDX_W+2].
REQ-019 Lookup: one cycle after fetch_valid=1, pred_valid=1; pred_taken=1 iff entry valid, tag matches, counter[1]=1; pred_target = entry target when pred_taken=1, else fetch_pc+4.
REQ-020 When fetch_valid=0, the next cycle SHALL have pred_valid=0 and pred_taken=0; pred_target holds its value.
REQ-021 Actual outcome: act_taken = ex_is_jump | (ex_is_branch & ex_taken); act_target = jump_pc if ex_is_jump, else branch_pc.
REQ-022 Update on ex_valid & (ex_is_branch|ex_is_jump), at the index of ex_pc: on tag hit, counter saturating +1 if act_taken, -1 otherwise; target written when act_taken.
REQ-023 On tag miss or invalid entry: allocate only if act_taken (valid=1, tag, target; counter=2'b10 for branch, 2'b11 for jump); not-taken miss SHALL leave the entry unchanged.
REQ-024 Jumps on tag hit SHALL set counter to 2'b11.
REQ-025 Counter SHALL saturate at 2'b00 and 2'b11, never wrap.
REQ-026 Same-cycle lookup and update of the same index: lookup SHALL return pre-update contents (read-before-write).
REQ-027 mispredict SHALL be 1 in the cycle after ex_valid=1 when act_taken != ex_pred_taken, or when act_taken=1 and ex_pred_target != act_target; otherwise 0.
REQ-028 redirect_pc SHALL register act_target if act_taken, else updated_pc, on every ex_valid cycle.
REQ-029 ex_valid with ex_is_branch=ex_is_jump=0 SHALL not modify BTB; mispredict is then evaluated with act_taken=0.

Reset
REQ-030 rst=1 SHALL clear all BTB valid bits, counters to 2'b01, pred_valid=0, pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0, stat counters=0.
REQ-031 rst SHALL take priority over concurrent lookup/update; an update present in the reset cycle SHALL be discarded.
REQ-032 First edge after rst deasserts SHALL process inputs normally.

Configuration
REQ-033 Macro BPU_STATS_EN defined: stat_lookups increments on each fetch_valid=1 cycle, stat_mispredicts on each cycle mispredict is set; both saturate at 32'hFFFF_FFFF; undefined: counter logic absent, both ports tied to 0.

Verification
REQ-034 Reset, then fetch_pc=0x0000_0040 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x0000_0044.
REQ-035 Taken branch ex_pc=0x40, updated_pc=0x44, branch_offset=3, ex_pred_taken=0 -> branch_pc=0x50, mispredict=1, redirect_pc=0x50; later fetch 0x40 -> pred_taken=1, pred_target=0x50.
REQ-036 Same branch not taken twice -> counter 10->01->00; fetch 0x40 -> pred_taken=0; a third not-taken keeps counter 00.
REQ-037 Jump updated_pc=0x1000_0008, instruction[25:0]=0x000_0100 -> jump_pc=0x1000_0400, entry counter=2'b11.
REQ-038 Lookup and update of index 0x40 in the same cycle after reset -> pred_taken=0 that cycle; next lookup pred_taken=1.
REQ-039 With BPU_STATS_EN: 5 lookups, 2 mispredicts -> stat_lookups=5, stat_mispredicts=2; rst -> both 0.
